lsu_mem_port: RTL and testbench

Load/store data port between the memory pipeline stage and the data memory. Stores are packed into word-aligned memory writes: byte lane placement, lane replication and byte enables. Loads run the opposite way: the addressed byte or halfword is extracted from the returned word and sign- or zero-extended to 32 bits. The memory side uses a req/ack handshake, so the memory may insert any number of wait states.

---
 rtl/lsu_mem_port.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store lane packing and extraction over a req/ack data memory port
// Optional alignment/reserved-size error checking: define LSU_ALIGN_CHECK_EN.
module lsu_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;

    logic [1:0]  size_eff;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);

    // Request-side packing: lane enables and replicated store data.
    always_comb begin
        size_eff = req_size;
`ifndef LSU_ALIGN_CHECK_EN
        if (req_size == 2'b11) size_eff = 2'b10;
`endif
        case (size_eff)
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = req_wdata;
            end
        endcase
    end

    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        req_err = ((req_size == 2'b01) && req_addr[0])
               || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
               || (req_size == 2'b11);
`else
        req_err = 1'b0;
`endif
    end

    // Response-side extraction from the returned word using the latched lane.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= size_eff;
                        lane_q   <= req_addr[1:0];
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= DONE;
                        end else begin
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                            mem_req   <= 1'b1;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? 32'h0 : load_ext;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed testbench for lsu_mem_port
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction with ack after 'waits' idle BUSY cycles.
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        @(negedge clk);
        chk({tag, "_ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_mem_req"}, mem_req, 1'b1);
        chk({tag, "_mem_we"}, mem_we, we);
        chk({tag, "_mem_addr"}, mem_addr, exp_addr);
        chk({tag, "_mem_be"}, mem_be, exp_be);
        chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        chk({tag, "_ready_busy"}, req_ready, 1'b0);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_no_resp_wait"}, resp_valid, 1'b0);
            @(negedge clk);
            chk({tag, "_req_held"}, mem_req, 1'b1);
            chk({tag, "_be_held"}, mem_be, exp_be);
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        chk({tag, "_resp_valid"}, resp_valid, 1'b1);
        chk({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_resp_err"}, resp_err, 1'b0);
        chk({tag, "_req_dropped"}, mem_req, 1'b0);
        chk({tag, "_ready_done"}, req_ready, 1'b0);
        @(negedge clk);
        chk({tag, "_resp_pulse"}, resp_valid, 1'b0);
        chk({tag, "_ready_back"}, req_ready, 1'b1);
        chk({tag, "_rdata_hold"}, resp_rdata, exp_rdata);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", mem_be, 4'b0000);
        chk("rst_mem_wdata", mem_wdata, 32'h0);

        access("st_byte", 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 3,
               32'hDEAD_BEEF, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access("ld_half_s", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 1,
               32'h8001_1234, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
        access("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 1,
               32'h8001_1234, 32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001);
        access("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 0,
               32'h0000_F200, 32'h0000_2000, 4'b0010, 32'h0, 32'hFFFF_FFF2);
        access("ld_byte_u", 1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 0,
               32'h9A00_0000, 32'h0000_2000, 4'b1000, 32'h0, 32'h0000_009A);
        access("st_half", 1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hABCD_1234, 2,
               32'hFFFF_FFFF, 32'h0000_0010, 4'b0011, 32'h1234_1234, 32'h0);
        access("ld_word", 1'b0, 2'b10, 1'b1, 32'h0000_4000, 32'h0, 0,
               32'h8765_4321, 32'h0000_4000, 4'b1111, 32'h0, 32'h8765_4321);

`ifdef LSU_ALIGN_CHECK_EN
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h0000_3002; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mis_resp_valid", resp_valid, 1'b1);
        chk("mis_resp_err", resp_err, 1'b1);
        chk("mis_resp_rdata", resp_rdata, 32'h0);
        chk("mis_no_mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk("mis_pulse", resp_valid, 1'b0);
        chk("mis_err_hold", resp_err, 1'b1);
        chk("mis_no_mem_req2", mem_req, 1'b0);
        chk("mis_ready", req_ready, 1'b1);
`else
        access("mis_word", 1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 0,
               32'h0102_0304, 32'h0000_3000, 4'b1111, 32'h0, 32'h0102_0304);
        access("rsv_size", 1'b1, 2'b11, 1'b0, 32'h0000_3006, 32'hCAFE_F00D, 0,
               32'h0, 32'h0000_3004, 4'b1111, 32'hCAFE_F00D, 32'h0);
`endif

        // Reset while BUSY, then a stray ack.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h0000_5000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstb_mem_req", mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstb_req_drop", mem_req, 1'b0);
        chk("rstb_ready", req_ready, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rstb_late_ack", resp_valid, 1'b0);
        chk("rstb_late_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        chk("rstb_late_ack2", resp_valid, 1'b0);
        chk("rstb_idle_req", mem_req, 1'b0);

        // Back-to-back with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_6000;
        @(negedge clk);
        req_addr = 32'h0000_6004;
        chk("b2b_busy_ready", req_ready, 1'b0);
        chk("b2b_first_addr", mem_addr, 32'h0000_6000);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_resp1", resp_valid, 1'b1);
        chk("b2b_rdata1", resp_rdata, 32'h1111_1111);
        chk("b2b_done_ready", req_ready, 1'b0);
        chk("b2b_done_noreq", mem_req, 1'b0);
        @(negedge clk);
        chk("b2b_idle_ready", req_ready, 1'b1);
        chk("b2b_idle_noreq", mem_req, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_second_req", mem_req, 1'b1);
        chk("b2b_second_addr", mem_addr, 32'h0000_6004);
        chk("b2b_second_ready", req_ready, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_resp2", resp_valid, 1'b1);
        chk("b2b_rdata2", resp_rdata, 32'h2222_2222);
        @(negedge clk);
        chk("b2b_end_pulse", resp_valid, 1'b0);
        chk("b2b_end_ready", req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
